// File: rtl/reg_file_sb_pkg.sv
// Shared definitions for the register file with scoreboard.
//   XLEN_DEF / NREG_DEF : default data width and register count
//   aw()                : address width for a given register count
//   rf_state_t          : clear-sweep / run state encoding
package rf_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned NREG_DEF = 32;

    typedef enum logic {
        CLEAR,
        RUN
    } rf_state_t;

    function automatic int unsigned aw(input int unsigned nreg);
        return (nreg < 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Bus bundle between the core pipeline and the register file.
//   ra/rd/rd_busy : NUM_RD packed read ports (address, data, busy flag)
//   we/wa/wd      : single write port
//   iss_vld/iss_rd: issue notification marking a destination as pending
//   ready         : file has finished its post-reset clear sweep
// master = pipeline side, slave = register file side.
interface reg_file_sb_if
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NUM_RD = 2
) ();
    localparam int unsigned AW = aw(NREG);

    logic [NUM_RD*AW-1:0]   ra;
    logic [NUM_RD*XLEN-1:0] rd;
    logic [NUM_RD-1:0]      rd_busy;
    logic                   we;
    logic [AW-1:0]          wa;
    logic [XLEN-1:0]        wd;
    logic                   iss_vld;
    logic [AW-1:0]          iss_rd;
    logic                   ready;

    modport master (
        output ra, we, wa, wd, iss_vld, iss_rd,
        input  rd, rd_busy, ready
    );

    modport slave (
        input  ra, we, wa, wd, iss_vld, iss_rd,
        output rd, rd_busy, ready
    );
endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, bit 0 always clear.
//   clk, rst   : clock, async active-high reset (clears every bit)
//   set_vld/idx: mark register as having an outstanding producer
//   clr_vld/idx: writeback of register, clears its bit
//   ra         : packed per-port lookup addresses
//   busy_out   : per-port busy bit of the addressed register
// When set and clear target the same register, set wins: the issuing
// instruction is a newer producer than the one writing back.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned AW     = aw(NREG)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_vld,
    input  logic [AW-1:0]        set_idx,
    input  logic                 clr_vld,
    input  logic [AW-1:0]        clr_idx,
    input  logic [NUM_RD*AW-1:0] ra,
    output logic [NUM_RD-1:0]    busy_out
);
    logic [NREG-1:0] busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy[0] <= 1'b0;
            for (int unsigned i = 1; i < NREG; i++) begin
                if (set_vld && set_idx == AW'(i)) begin
                    busy[i] <= 1'b1;
                end else if (clr_vld && clr_idx == AW'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy_out = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            busy_out[p] = busy[ra[p*AW +: AW]];
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Integer register file: NUM_RD combinational read ports, one write port,
// hardwired zero register, optional write->read bypass, pending-write
// scoreboard. After reset a sweep zeroes registers 1..NREG-1 so the array
// itself needs no reset and can map onto RAM.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (restarts the sweep)
//   bus : reg_file_sb_if slave (read ports, write port, issue, ready)
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned NUM_RD = 2,
    parameter bit          BYPASS = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_sb_if.slave  bus
);
    localparam int unsigned AW = aw(NREG);

    rf_state_t       state;
    logic [AW-1:0]   ptr;
    logic            ready_q;
    logic [XLEN-1:0] mem [NREG];
    logic            run;
    logic            wr_en;
    logic [NUM_RD-1:0] sb_busy;

    assign run   = (state == RUN);
    assign wr_en = run && bus.we && (bus.wa != '0);

    // Sweep FSM: ready rises together with the RUN transition, after
    // the edge that clears register NREG-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            ptr     <= AW'(1);
            ready_q <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    ptr <= ptr + AW'(1);
                    if (ptr == AW'(NREG - 1)) begin
                        state   <= RUN;
                        ready_q <= 1'b1;
                    end
                end
                RUN: ;
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage has no reset; the sweep provides the initial zeros.
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[bus.wa] <= bus.wd;
        end
    end

    rf_scoreboard #(
        .NREG   (NREG),
        .NUM_RD (NUM_RD),
        .AW     (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_vld  (run && bus.iss_vld && (bus.iss_rd != '0)),
        .set_idx  (bus.iss_rd),
        .clr_vld  (wr_en),
        .clr_idx  (bus.wa),
        .ra       (bus.ra),
        .busy_out (sb_busy)
    );

    // Register 0 and the clear sweep both read as zero and never busy;
    // a bypassed read carries the incoming data, so it is not pending.
    always_comb begin
        bus.rd      = '0;
        bus.rd_busy = '0;
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            if (run && bus.ra[p*AW +: AW] != '0) begin
                if (BYPASS && wr_en && bus.wa == bus.ra[p*AW +: AW]) begin
                    bus.rd[p*XLEN +: XLEN] = bus.wd;
                end else begin
                    bus.rd[p*XLEN +: XLEN] = mem[bus.ra[p*AW +: AW]];
                    bus.rd_busy[p]         = sb_busy[p];
                end
            end
        end
    end

    assign bus.ready = ready_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int NUM_RD = 3;
    localparam int AW     = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD)) bus_if ();
    reg_file_sb_if #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD)) nb_if ();

    assign nb_if.ra      = bus_if.ra;
    assign nb_if.we      = bus_if.we;
    assign nb_if.wa      = bus_if.wa;
    assign nb_if.wd      = bus_if.wd;
    assign nb_if.iss_vld = bus_if.iss_vld;
    assign nb_if.iss_rd  = bus_if.iss_rd;

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .BYPASS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    reg_file_sb #(.XLEN(XLEN), .NREG(NREG), .NUM_RD(NUM_RD), .BYPASS(1'b0)) dut_nb (
        .clk (clk),
        .rst (rst),
        .bus (nb_if)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: architectural contents, pending set, sweep progress.
    logic [XLEN-1:0] m_reg [NREG];
    bit              m_busy [NREG];
    bit              m_ready;
    int              m_cnt;

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] ra_of(input int p);
        return bus_if.ra[p*AW +: AW];
    endfunction

    task automatic check_all(input string tag);
        logic [AW-1:0]   a;
        logic [XLEN-1:0] e_rd, e_rd_nb;
        bit              e_b, e_b_nb, hit;
        chk({tag, ".ready"}, XLEN'(bus_if.ready), XLEN'(m_ready));
        chk({tag, ".ready_nb"}, XLEN'(nb_if.ready), XLEN'(m_ready));
        for (int p = 0; p < NUM_RD; p++) begin
            a = ra_of(p);
            hit = bus_if.we && bus_if.wa == a;
            if (!m_ready || a == 0) begin
                e_rd = '0; e_rd_nb = '0; e_b = 0; e_b_nb = 0;
            end else begin
                e_rd    = hit ? bus_if.wd : m_reg[a];
                e_b     = hit ? 1'b0 : m_busy[a];
                e_rd_nb = m_reg[a];
                e_b_nb  = m_busy[a];
            end
            chk($sformatf("%s.rd%0d", tag, p), bus_if.rd[p*XLEN +: XLEN], e_rd);
            chk($sformatf("%s.busy%0d", tag, p), XLEN'(bus_if.rd_busy[p]), XLEN'(e_b));
            chk($sformatf("%s.rd_nb%0d", tag, p), nb_if.rd[p*XLEN +: XLEN], e_rd_nb);
            chk($sformatf("%s.busy_nb%0d", tag, p), XLEN'(nb_if.rd_busy[p]), XLEN'(e_b_nb));
        end
    endtask

    task automatic set_in(input bit we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                          input bit iv, input logic [AW-1:0] ir,
                          input logic [AW-1:0] r0, input logic [AW-1:0] r1, input logic [AW-1:0] r2);
        bus_if.we      = we;
        bus_if.wa      = wa;
        bus_if.wd      = wd;
        bus_if.iss_vld = iv;
        bus_if.iss_rd  = ir;
        bus_if.ra      = {r2, r1, r0};
        #1;
    endtask

    // Advance one clock; model follows the rules using the inputs held over the edge.
    task automatic tick();
        @(posedge clk);
        if (!m_ready) begin
            m_cnt++;
            if (m_cnt == NREG - 1) begin
                m_ready = 1;
                for (int i = 0; i < NREG; i++) m_reg[i] = '0;
            end
        end else begin
            if (bus_if.we && bus_if.wa != 0) begin
                m_reg[bus_if.wa]  = bus_if.wd;
                m_busy[bus_if.wa] = 0;
            end
            if (bus_if.iss_vld && bus_if.iss_rd != 0) m_busy[bus_if.iss_rd] = 1;
        end
        #1;
    endtask

    // Assert reset mid-cycle, check it takes effect before any edge, release after next edge.
    task automatic mid_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        m_ready = 0;
        m_cnt   = 0;
        for (int i = 0; i < NREG; i++) m_busy[i] = 0;
        chk({tag, ".ready_async"}, XLEN'(bus_if.ready), '0);
        check_all(tag);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_sweep(input string tag);
        int n = 0;
        while (n < 100) begin
            check_all(tag);
            if (bus_if.ready) break;
            tick();
            n++;
        end
        chk({tag, ".sweep_len"}, XLEN'(n), XLEN'(NREG - 1));
    endtask

    typedef struct {
        bit              we;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
        bit              iv;
        logic [AW-1:0]   ir;
        logic [AW-1:0]   r0, r1, r2;
        logic [XLEN-1:0] e_rd;
        logic [XLEN-1:0] e_rd_nb;
        bit              e_b;
        bit              e_b_nb;
    } vec_t;

    vec_t vt [12];

    initial begin
        vt[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 5, 0, 0, 32'hDEADBEEF, 32'h0,        0, 0};
        vt[1]  = '{0, 0, 32'h0,        0, 0, 5, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0};
        vt[2]  = '{1, 0, 32'hFFFFFFFF, 1, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0};
        vt[3]  = '{0, 0, 32'h0,        0, 0, 0, 0, 0, 32'h0,        32'h0,        0, 0};
        vt[4]  = '{0, 0, 32'h0,        1, 7, 7, 0, 0, 32'h0,        32'h0,        0, 0};
        vt[5]  = '{1, 7, 32'hAAAA5555, 1, 7, 7, 0, 0, 32'hAAAA5555, 32'h0,        0, 1};
        vt[6]  = '{0, 0, 32'h0,        0, 0, 7, 0, 0, 32'hAAAA5555, 32'hAAAA5555, 1, 1};
        vt[7]  = '{1, 7, 32'h00C0FFEE, 0, 0, 7, 0, 0, 32'h00C0FFEE, 32'hAAAA5555, 0, 1};
        vt[8]  = '{0, 0, 32'h0,        0, 0, 7, 0, 0, 32'h00C0FFEE, 32'h00C0FFEE, 0, 0};
        vt[9]  = '{1, 9, 32'h12345678, 0, 0, 9, 9, 9, 32'h12345678, 32'h0,        0, 0};
        vt[10] = '{0, 0, 32'h0,        0, 0, 9, 9, 9, 32'h12345678, 32'h12345678, 0, 0};
        vt[11] = '{1, 9, 32'h00000001, 0, 0, 9, 5, 7, 32'h00000001, 32'h12345678, 0, 0};

        for (int i = 0; i < NREG; i++) begin
            m_reg[i]  = '0;
            m_busy[i] = 0;
        end
        m_ready = 0;
        m_cnt   = 0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);

        // Power-on reset, then the sweep: ready low for NREG-1 cycles, reads zero.
        @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.ready", XLEN'(bus_if.ready), '0);
        rst = 1'b0;
        set_in(1, 3, 32'h55, 1, 4, 3, 4, 1);   // must be ignored during the sweep
        wait_sweep("sweep0");
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        check_all("post_sweep");

        // Directed vectors.
        for (int i = 0; i < 12; i++) begin
            set_in(vt[i].we, vt[i].wa, vt[i].wd, vt[i].iv, vt[i].ir, vt[i].r0, vt[i].r1, vt[i].r2);
            chk($sformatf("vec%0d.rd0", i), bus_if.rd[0 +: XLEN], vt[i].e_rd);
            chk($sformatf("vec%0d.rd0_nb", i), nb_if.rd[0 +: XLEN], vt[i].e_rd_nb);
            chk($sformatf("vec%0d.busy0", i), XLEN'(bus_if.rd_busy[0]), XLEN'(vt[i].e_b));
            chk($sformatf("vec%0d.busy0_nb", i), XLEN'(nb_if.rd_busy[0]), XLEN'(vt[i].e_b_nb));
            check_all($sformatf("vec%0d", i));
            tick();
        end

        // Randomised traffic on a narrow address range to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)),
                   AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 31)));
            check_all("rand");
            tick();
        end

        // Reset mid-sweep at ptr=10.
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        mid_reset("rst_a");
        for (int i = 0; i < 9; i++) begin
            check_all("part_sweep");
            tick();
        end
        mid_reset("rst_sweep");
        wait_sweep("sweep1");

        // Reset mid-run with register 3 written and pending.
        set_in(1, 3, 32'h33333333, 1, 3, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 0, 0, 3, 3, 0);
        chk("run3.busy", XLEN'(bus_if.rd_busy[0]), 32'h1);
        chk("run3.rd", bus_if.rd[0 +: XLEN], 32'h33333333);
        check_all("run3");
        mid_reset("rst_run");
        chk("rst_run.rd3", bus_if.rd[0 +: XLEN], '0);
        chk("rst_run.busy3", XLEN'(bus_if.rd_busy[0]), '0);
        wait_sweep("sweep2");
        chk("after.rd3", bus_if.rd[0 +: XLEN], '0);
        chk("after.busy3", XLEN'(bus_if.rd_busy[0]), '0);
        chk("after.rd3_nb", nb_if.rd[0 +: XLEN], '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
